display_scan_scheduler: RTL and testbench
=========================================

// Module: display_scan_scheduler
// PURPOSE
//   Time-multiplexes one shared 8-bit segment bus across four common-line digits.
//   Sits between the timer/counter value registers and the uo_out/uio_out[3:0] pads.
//   Snapshots a 4-nibble value once per frame so the display never tears.
//   Inserts a blanking gap before each digit to suppress ghosting.
// PARAMETERS
//   CLK_DIV    1000  clocks per digit slot (blank + show); legal range 4..65535
//   BLANK_CYC  16    clocks per slot with all outputs off; must be >= 1 and < CLK_DIV
// PORTS
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   enable     in   1   1 = scan, 0 = display dark
//   inv        in   1   1 = invert segment and digit polarity (common-anode boards)
//   digit_val  in   16  4 hex nibbles; [3:0] = digit 0 (rightmost)
//   dp_mask    in   4   decimal point per digit; bit i -> digit i
//   segment    out  8   {dp,g,f,e,d,c,b,a}, registered
//   digit      out  4   one-hot digit strobe, registered
//   frame_done out  1   one-cycle pulse at end of digit 3 show phase
// BEHAVIOUR
//   - One clock (clk); reset is asynchronous and active-low (rst_n).
//   - Reset: state IDLE, idx=0, prescaler=0, snapshot=0, segment=8'h00, digit=4'h0, frame_done=0.
//   - States: IDLE, BLANK, SHOW.
//     IDLE : enable=1 -> BLANK, idx=0, prescaler=0, snapshot <= {dp_mask,digit_val}.
//     BLANK: after BLANK_CYC clocks -> SHOW.
//     SHOW : after CLK_DIV-BLANK_CYC clocks -> BLANK, idx=idx+1 mod 4.
//     Leaving SHOW with idx=3: frame_done=1 for one cycle; new snapshot taken on the same edge.
//     Any state with enable=0 sampled -> IDLE next cycle; idx and prescaler cleared.
//   - Snapshot is loaded only at frame start; inputs changing mid-frame do not affect the current frame.
//   - Logical outputs (before inv):
//     BLANK/IDLE: seg=8'h00, dig=4'h0.
//     SHOW: dig=1<<idx; seg={dp[idx], hex7(nibble[idx])}.
//   - hex7, gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//   - Registered outputs: segment = seg ^ {8{inv}}, digit = dig ^ {4{inv}}.
//     inv is sampled every cycle; a change is visible one cycle later, including in IDLE.
//   - Latency: enable high sampled at edge t -> BLANK from t. First SHOW outputs appear on the edge BLANK_CYC+1 after t.
//   - Period: slot = CLK_DIV clocks exactly; frame = 4*CLK_DIV clocks; frame_done has period 4*CLK_DIV.
//   - Never more than one digit strobe is active; the strobe is never active during BLANK.
//   - Reset asserted mid-frame: outputs go to reset values immediately (asynchronously).
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined:
//     In SHOW, digit i (i=3..1) is fully dark (seg=0, dig=0, then inv applied) when
//     nibble[i..3]==0 and dp[i..3]==0. Digit 0 is always shown. Slot timing is unchanged.
//   Not defined: all four digits are always shown.
// TESTING (CLK_DIV=8, BLANK_CYC=2)
//   1. Reset, then enable=1, inv=0, digit_val=16'h1234, dp=0.
//      -> digit 0001/0010/0100/1000 with segment 66/4F/5B/06.
//      -> each show phase lasts 6 clocks with 2 dark clocks between; frame_done pulses every 32 clocks.
//   2. Change digit_val to 16'hABCD mid-frame.
//      -> current frame still shows 1234; the next frame shows d,C,b,A (5E,39,7C,77).
//   3. inv=1, digit_val=16'h0008, dp_mask=4'b0001.
//      -> digit-0 show phase: segment=8'h00 (inverted FF), digit=4'b1110.
//      -> blank phases: segment=FF, digit=F.
//   4. Drop enable during digit 2 show.
//      -> next cycle: segment=00, digit=0, no frame_done.
//      -> re-enable: scan restarts at digit 0 after 2 blank clocks.
//   5. Assert rst_n=0 asynchronously mid-SHOW.
//      -> segment/digit/frame_done are 0 before the next clk edge; the scan resumes from IDLE.
//   6. LEADING_ZERO_BLANK_EN defined, digit_val=16'h0050.
//      -> digits 3 and 2 dark; digit 1 shows 6D; digit 0 shows 3F.

Source files
------------

// File: rtl/display_scan_scheduler.sv
// Four-digit multiplexed 7-segment scan scheduler with per-frame snapshot and anti-ghost blanking.
// Optional build macro: LEADING_ZERO_BLANK_EN (dark leading zero digits 3..1).
module display_scan_scheduler #(
    parameter int CLK_DIV   = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        inv,
    input  logic [15:0] digit_val,
    input  logic [3:0]  dp_mask,
    output logic [7:0]  segment,
    output logic [3:0]  digit,
    output logic        frame_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);
    localparam logic [15:0] SHOW_LAST  = 16'(CLK_DIV - BLANK_CYC - 1);

    logic [1:0]  state_r, state_s;
    logic [1:0]  idx_r, idx_s;
    logic [15:0] presc_r, presc_s;
    logic [19:0] snap_r, snap_s;
    logic        frame_done_s;
    logic [7:0]  segment_r, seg_s;
    logic [3:0]  digit_r, dig_s;
    logic [3:0]  nibble_s;
    logic        dp_s;
    logic        lead_dark_s;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            4'hF: pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // Next-state logic: phase sequencing, digit index, snapshot capture at frame start.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        presc_s      = presc_r;
        snap_s       = snap_r;
        frame_done_s = 1'b0;
        if (!enable) begin
            state_s = ST_IDLE;
            idx_s   = 2'd0;
            presc_s = 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_BLANK;
                    idx_s   = 2'd0;
                    presc_s = 16'd0;
                    snap_s  = {dp_mask, digit_val};
                end
                ST_BLANK: begin
                    if (presc_r == BLANK_LAST) begin
                        state_s = ST_SHOW;
                        presc_s = 16'd0;
                    end else begin
                        presc_s = presc_r + 16'd1;
                    end
                end
                ST_SHOW: begin
                    if (presc_r == SHOW_LAST) begin
                        state_s = ST_BLANK;
                        presc_s = 16'd0;
                        idx_s   = idx_r + 2'd1;
                        if (idx_r == 2'd3) begin
                            frame_done_s = 1'b1;
                            snap_s       = {dp_mask, digit_val};
                        end else begin
                            frame_done_s = 1'b0;
                        end
                    end else begin
                        presc_s = presc_r + 16'd1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    idx_s   = 2'd0;
                    presc_s = 16'd0;
                end
            endcase
        end
    end

    // Select the snapshot nibble and decimal point for the digit being scanned.
    always_comb begin
        nibble_s = 4'h0;
        dp_s     = 1'b0;
        case (idx_r)
            2'd0: begin nibble_s = snap_r[3:0];   dp_s = snap_r[16]; end
            2'd1: begin nibble_s = snap_r[7:4];   dp_s = snap_r[17]; end
            2'd2: begin nibble_s = snap_r[11:8];  dp_s = snap_r[18]; end
            2'd3: begin nibble_s = snap_r[15:12]; dp_s = snap_r[19]; end
            default: begin nibble_s = 4'h0; dp_s = 1'b0; end
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:1] zero_s;
    assign zero_s[3] = (snap_r[15:12] == 4'h0) && !snap_r[19];
    assign zero_s[2] = (snap_r[11:8]  == 4'h0) && !snap_r[18];
    assign zero_s[1] = (snap_r[7:4]   == 4'h0) && !snap_r[17];

    // A digit goes dark only if it and every digit to its left are blank zeros.
    always_comb begin
        lead_dark_s = 1'b0;
        case (idx_r)
            2'd3:    lead_dark_s = zero_s[3];
            2'd2:    lead_dark_s = zero_s[3] & zero_s[2];
            2'd1:    lead_dark_s = zero_s[3] & zero_s[2] & zero_s[1];
            default: lead_dark_s = 1'b0;
        endcase
    end
`else
    assign lead_dark_s = 1'b0;
`endif

    // Logical outputs before polarity; enable gates them so a drop goes dark on the next edge.
    always_comb begin
        seg_s = 8'h00;
        dig_s = 4'h0;
        if (enable && (state_r == ST_SHOW) && !lead_dark_s) begin
            seg_s = {dp_s, hex7(nibble_s)};
            dig_s = 4'b0001 << idx_r;
        end else begin
            seg_s = 8'h00;
            dig_s = 4'h0;
        end
    end

    // State, counters, snapshot and polarity-adjusted output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= 2'd0;
            presc_r      <= 16'd0;
            snap_r       <= 20'd0;
            segment_r    <= 8'h00;
            digit_r      <= 4'h0;
            frame_done   <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            presc_r      <= presc_s;
            snap_r       <= snap_s;
            segment_r    <= seg_s ^ {8{inv}};
            digit_r      <= dig_s ^ {4{inv}};
            frame_done   <= frame_done_s;
        end
    end

    assign segment = segment_r;
    assign digit   = digit_r;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Directed self-checking bench for display_scan_scheduler (CLK_DIV=8, BLANK_CYC=2).
`timescale 1ns/1ps
module tb_display_scan_scheduler;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        inv;
    logic [15:0] digit_val;
    logic [3:0]  dp_mask;
    logic [7:0]  segment;
    logic [3:0]  digit;
    logic        frame_done;

    int total;
    int bad;

    display_scan_scheduler #(.CLK_DIV(8), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .inv        (inv),
        .digit_val  (digit_val),
        .dp_mask    (dp_mask),
        .segment    (segment),
        .digit      (digit),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; inv = 1'b0; digit_val = 16'h0000; dp_mask = 4'h0;
        #12;
        total++; if (segment !== 8'h00) begin bad++; $display("FAIL reset_seg got=%h want=00", segment); end
        total++; if (digit !== 4'h0) begin bad++; $display("FAIL reset_dig got=%h want=0", digit); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b want=0", frame_done); end
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();
        total++; if (segment !== 8'h00 || digit !== 4'h0) begin
            bad++; $display("FAIL idle_dark got=%h/%h want=00/0", segment, digit);
        end
    endtask

    // Two frames: 1234 then ABCD (value changed mid-frame 0).
    task automatic test_scan();
        int m; int d; logic [31:0] tbl; logic [7:0] es; logic [3:0] ed; logic efd;
        digit_val = 16'h1234; dp_mask = 4'h0; enable = 1'b1;
        for (int k = 1; k <= 65; k++) begin
            step();
            m = k - 4;
            if (m >= 0 && (m % 8) < 6) begin
                d   = (m / 8) % 4;
                tbl = (m >= 32) ? 32'h777C395E : 32'h065B4F66;
                es  = tbl[d*8 +: 8];
                ed  = 4'b0001 << d;
            end else begin
                es = 8'h00; ed = 4'h0;
            end
            efd = (k == 33 || k == 65);
            total++; if (segment !== es) begin bad++; $display("FAIL scan_seg k=%0d got=%h want=%h", k, segment, es); end
            total++; if (digit !== ed) begin bad++; $display("FAIL scan_dig k=%0d got=%h want=%h", k, digit, ed); end
            total++; if (frame_done !== efd) begin bad++; $display("FAIL scan_fd k=%0d got=%b want=%b", k, frame_done, efd); end
            if (k == 10) digit_val = 16'hABCD;
        end
    endtask

    task automatic test_invert();
        int m; int d; logic [31:0] tbl; logic [3:0] lz; logic [7:0] es; logic [3:0] ed; logic efd;
        enable = 1'b0;
        step(); step();
        total++; if (segment !== 8'h00 || digit !== 4'h0) begin
            bad++; $display("FAIL inv_idle0 got=%h/%h want=00/0", segment, digit);
        end
        inv = 1'b1;
        step();
        total++; if (segment !== 8'hFF || digit !== 4'hF) begin
            bad++; $display("FAIL inv_idle1 got=%h/%h want=FF/F", segment, digit);
        end
        digit_val = 16'h0008; dp_mask = 4'b0001; enable = 1'b1;
        tbl = 32'h3F3F3FFF;
`ifdef LEADING_ZERO_BLANK_EN
        lz = 4'b1110;
`else
        lz = 4'b0000;
`endif
        for (int k = 1; k <= 33; k++) begin
            step();
            m = k - 4;
            d = (m >= 0) ? (m / 8) % 4 : 0;
            if (m >= 0 && (m % 8) < 6 && !lz[d]) begin
                es = tbl[d*8 +: 8];
                ed = 4'b0001 << d;
            end else begin
                es = 8'h00; ed = 4'h0;
            end
            es  = es ^ 8'hFF;
            ed  = ed ^ 4'hF;
            efd = (k == 33);
            total++; if (segment !== es) begin bad++; $display("FAIL inv_seg k=%0d got=%h want=%h", k, segment, es); end
            total++; if (digit !== ed) begin bad++; $display("FAIL inv_dig k=%0d got=%h want=%h", k, digit, ed); end
            total++; if (frame_done !== efd) begin bad++; $display("FAIL inv_fd k=%0d got=%b want=%b", k, frame_done, efd); end
        end
    endtask

    task automatic test_enable_drop();
        enable = 1'b0;
        step(); step();
        inv = 1'b0; digit_val = 16'h1234; dp_mask = 4'h0;
        step();
        enable = 1'b1;
        for (int k = 1; k <= 20; k++) step();
        total++; if (segment !== 8'h5B || digit !== 4'b0100) begin
            bad++; $display("FAIL drop_pre got=%h/%h want=5B/4", segment, digit);
        end
        enable = 1'b0;
        step();
        total++; if (segment !== 8'h00 || digit !== 4'h0 || frame_done !== 1'b0) begin
            bad++; $display("FAIL drop_dark got=%h/%h/%b want=00/0/0", segment, digit, frame_done);
        end
        for (int k = 0; k < 40; k++) begin
            step();
            total++; if (digit !== 4'h0 || frame_done !== 1'b0) begin
                bad++; $display("FAIL drop_idle k=%0d got=%h/%b want=0/0", k, digit, frame_done);
            end
        end
        enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k < 4) begin
                total++; if (digit !== 4'h0) begin bad++; $display("FAIL reen_blank k=%0d got=%h want=0", k, digit); end
            end else begin
                total++; if (segment !== 8'h66 || digit !== 4'b0001) begin
                    bad++; $display("FAIL reen_d0 got=%h/%h want=66/1", segment, digit);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        step();
        total++; if (segment !== 8'h66 || digit !== 4'b0001) begin
            bad++; $display("FAIL ar_pre got=%h/%h want=66/1", segment, digit);
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (segment !== 8'h00 || digit !== 4'h0 || frame_done !== 1'b0) begin
            bad++; $display("FAIL ar_async got=%h/%h/%b want=00/0/0", segment, digit, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k < 4) begin
                total++; if (digit !== 4'h0) begin bad++; $display("FAIL ar_blank k=%0d got=%h want=0", k, digit); end
            end else begin
                total++; if (segment !== 8'h66 || digit !== 4'b0001) begin
                    bad++; $display("FAIL ar_resume got=%h/%h want=66/1", segment, digit);
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [7:0] es; logic [3:0] ed;
        enable = 1'b0;
        step(); step();
        digit_val = 16'h0050; dp_mask = 4'h0; enable = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            step();
            if (k == 4 || k == 12 || k == 20 || k == 28) begin
                case (k)
                    4:  begin es = 8'h3F; ed = 4'b0001; end
                    12: begin es = 8'h6D; ed = 4'b0010; end
`ifdef LEADING_ZERO_BLANK_EN
                    20: begin es = 8'h00; ed = 4'b0000; end
                    default: begin es = 8'h00; ed = 4'b0000; end
`else
                    20: begin es = 8'h3F; ed = 4'b0100; end
                    default: begin es = 8'h3F; ed = 4'b1000; end
`endif
                endcase
                total++; if (segment !== es || digit !== ed) begin
                    bad++; $display("FAIL lz k=%0d got=%h/%h want=%h/%h", k, segment, digit, es, ed);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_scan();
        test_invert();
        test_enable_drop();
        test_async_reset();
        test_leading_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
